// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared FSM state type and sizing helper for serial_adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  // Digit counter width; never below one bit even when a single slice covers the word.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// rtl/adder_slice.sv - combinational DIGIT-bit ripple adder slice exposing carry into its MSB
module adder_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] i_x,
  input  logic [DIGIT-1:0] i_y,
  input  logic             i_ci,
  output logic [DIGIT-1:0] o_s,
  output logic             o_co,
  output logic             o_c_msb
);

  logic [DIGIT:0] w_c;

  always_comb begin
    w_c    = '0;
    o_s    = '0;
    w_c[0] = i_ci;
    for (int i = 0; i < DIGIT; i++) begin
      o_s[i]   = i_x[i] ^ i_y[i] ^ w_c[i];
      w_c[i+1] = (i_x[i] & i_y[i]) | (w_c[i] & (i_x[i] ^ i_y[i]));
    end
  end

  assign o_co    = w_c[DIGIT];
  assign o_c_msb = w_c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - multi-cycle adder/subtractor processing DIGIT bits per clock
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c_in,
  input  logic             i_sub,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  sa_state_t        r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cy;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [DIGIT-1:0] w_s;
  logic             w_co;
  logic             w_c_msb;
  logic [WIDTH-1:0] w_a_next;
  logic [WIDTH-1:0] w_b_next;
  logic [WIDTH-1:0] w_sum_next;

  adder_slice #(.DIGIT(DIGIT)) u_slice (
    .i_x     (r_a[DIGIT-1:0]),
    .i_y     (r_b[DIGIT-1:0]),
    .i_ci    (r_cy),
    .o_s     (w_s),
    .o_co    (w_co),
    .o_c_msb (w_c_msb)
  );

  // Operands shift down one digit per cycle; result digits enter at the top and settle in place after N shifts.
  if (N == 1) begin : g_single
    assign w_a_next   = r_a;
    assign w_b_next   = r_b;
    assign w_sum_next = w_s;
  end else begin : g_multi
    assign w_a_next   = {{DIGIT{1'b0}}, r_a[WIDTH-1:DIGIT]};
    assign w_b_next   = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
    assign w_sum_next = {w_s, r_sum[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_cy        <= 1'b0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_in_valid) begin
            r_a        <= i_a;
            r_b        <= i_sub ? ~i_b : i_b;
            r_cy       <= i_sub | i_c_in;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          r_a   <= w_a_next;
          r_b   <= w_b_next;
          r_sum <= w_sum_next;
          r_cy  <= w_co;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_carry     <= w_co;
            r_ovf       <= w_c_msb ^ w_co;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_sum       = r_sum;
  assign o_carry     = r_carry;
  assign o_overflow  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed and scoreboard bench for serial_adder at DIGIT 4, 16 and 1
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        sub;
  logic        out_ready;
  logic [2:0]  in_valid;

  logic        in_ready_o  [3];
  logic        out_valid_o [3];
  logic [15:0] sum_o       [3];
  logic        carry_o     [3];
  logic        ovf_o       [3];

  int n_checks = 0;
  int n_errors = 0;
  int exp_lat [3] = '{4, 1, 16};

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid[0]), .o_in_ready(in_ready_o[0]),
    .i_a(a), .i_b(b), .i_c_in(c_in), .i_sub(sub), .o_out_valid(out_valid_o[0]),
    .i_out_ready(out_ready), .o_sum(sum_o[0]), .o_carry(carry_o[0]), .o_overflow(ovf_o[0])
  );

  serial_adder #(.WIDTH(16), .DIGIT(16)) u_dut16 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid[1]), .o_in_ready(in_ready_o[1]),
    .i_a(a), .i_b(b), .i_c_in(c_in), .i_sub(sub), .o_out_valid(out_valid_o[1]),
    .i_out_ready(out_ready), .o_sum(sum_o[1]), .o_carry(carry_o[1]), .o_overflow(ovf_o[1])
  );

  serial_adder #(.WIDTH(16), .DIGIT(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid[2]), .o_in_ready(in_ready_o[2]),
    .i_a(a), .i_b(b), .i_c_in(c_in), .i_sub(sub), .o_out_valid(out_valid_o[2]),
    .i_out_ready(out_ready), .o_sum(sum_o[2]), .o_carry(carry_o[2]), .o_overflow(ovf_o[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns {overflow, carry, sum} from plain 17-bit arithmetic and sign comparison.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mc, input logic ms);
    logic [15:0] bb;
    logic [16:0] r;
    logic        v;
    bb = ms ? ~mb : mb;
    r  = {1'b0, ma} + {1'b0, bb} + {16'd0, (ms ? 1'b1 : mc)};
    v  = (ma[15] == bb[15]) && (r[15] != ma[15]);
    return {v, r};
  endfunction

  task automatic do_op(input int k, input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic tc, input logic ts, input int bp,
                       output logic [15:0] rs, output logic rc, output logic rv);
    int w;
    int lat;
    w = 0;
    while (!in_ready_o[k] && w < 50) begin
      tick();
      w++;
    end
    check("in_ready_before_op", 32'(in_ready_o[k]), 32'd1);
    a = ta; b = tb_v; c_in = tc; sub = ts;
    in_valid[k] = 1'b1;
    tick();
    in_valid[k] = 1'b0;
    a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
    lat = 0;
    while (!out_valid_o[k] && lat < 40) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat[k]));
    for (int i = 0; i < bp; i++) tick();
    check("out_valid_held", 32'(out_valid_o[k]), 32'd1);
    rs = sum_o[k]; rc = carry_o[k]; rv = ovf_o[k];
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_drop", 32'(out_valid_o[k]), 32'd0);
  endtask

  task automatic directed(input string tag, input int k, input logic [15:0] ta,
                          input logic [15:0] tb_v, input logic tc, input logic ts,
                          input logic [15:0] es, input logic ec, input logic ev);
    logic [15:0] rs;
    logic        rc;
    logic        rv;
    do_op(k, ta, tb_v, tc, ts, 0, rs, rc, rv);
    check({tag, "_sum"}, 32'(rs), 32'(es));
    check({tag, "_carry"}, 32'(rc), 32'(ec));
    check({tag, "_ovf"}, 32'(rv), 32'(ev));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rcin;
    logic        rsub;
    logic [15:0] rs;
    logic        rc;
    logic        rv;
    logic [17:0] m;

    rst = 1'b1; in_valid = '0; out_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    for (int k = 0; k < 3; k++) begin
      check("reset_in_ready", 32'(in_ready_o[k]), 32'd1);
      check("reset_out_valid", 32'(out_valid_o[k]), 32'd0);
      check("reset_sum", 32'(sum_o[k]), 32'd0);
      check("reset_carry", 32'(carry_o[k]), 32'd0);
      check("reset_ovf", 32'(ovf_o[k]), 32'd0);
    end

    directed("add_cin", 0, 16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
    directed("wrap", 0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("pos_ovf", 0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("sub_borrow", 0, 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed("sub_ovf", 0, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Backpressure in DONE with noisy inputs.
    a = 16'h1111; b = 16'h2222; c_in = 1'b0; sub = 1'b0;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    repeat (4) tick();
    check("bp_out_valid_rise", 32'(out_valid_o[0]), 32'd1);
    for (int i = 0; i < 10; i++) begin
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
      in_valid[0] = 1'(i % 2);
      tick();
      check("bp_out_valid", 32'(out_valid_o[0]), 32'd1);
      check("bp_sum", 32'(sum_o[0]), 32'h3333);
      check("bp_in_ready", 32'(in_ready_o[0]), 32'd0);
    end
    a = 16'hAAAA; b = 16'h5555; in_valid[0] = 1'b1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_valid[0] = 1'b0;
    check("bp_release_in_ready", 32'(in_ready_o[0]), 32'd1);
    check("bp_release_out_valid", 32'(out_valid_o[0]), 32'd0);
    directed("after_bp", 0, 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);

    // Reset two cycles into BUSY drops the operation.
    a = 16'h1234; b = 16'h1111; c_in = 1'b0; sub = 1'b0;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready_o[0]), 32'd1);
    check("rst_out_valid", 32'(out_valid_o[0]), 32'd0);
    check("rst_sum", 32'(sum_o[0]), 32'd0);
    repeat (6) tick();
    check("rst_no_out_valid", 32'(out_valid_o[0]), 32'd0);
    directed("after_rst", 0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

    directed("d16", 1, 16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0);
    directed("d1", 2, 16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0);

    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 1000; n++) begin
        ra = 16'($urandom); rb = 16'($urandom);
        rcin = 1'($urandom); rsub = 1'($urandom);
        if (n % 8 == 0) ra = 16'h8000;
        if (n % 8 == 1) rb = 16'hFFFF;
        m = model(ra, rb, rcin, rsub);
        do_op(k, ra, rb, rcin, rsub, int'($urandom_range(0, 3)), rs, rc, rv);
        check("rand_sum", 32'(rs), 32'(m[15:0]));
        check("rand_carry", 32'(rc), 32'(m[16]));
        check("rand_ovf", 32'(rv), 32'(m[17]));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
